// File: rtl/mem_arbiter.sv
// Two-port data-memory arbiter. Port A is the pipeline MEM stage and normally
// wins. Port B is the debug/loader port: it wins after STARVE_LIMIT denied
// cycles, and it can hold the memory for one extra cycle for read-modify-write.
// Grants are combinational. Load responses come back one cycle after the grant.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // port A
  input  logic        aReq,
  input  logic        aWrite,
  input  logic [2:0]  aFunc3,
  input  logic [31:0] aAddr,
  input  logic [31:0] aWData,
  output logic        aGnt,
  output logic        aStall,
  output logic        aRValid,
  output logic [31:0] aRData,
  // port B
  input  logic        bReq,
  input  logic        bWrite,
  input  logic [2:0]  bFunc3,
  input  logic [31:0] bAddr,
  input  logic [31:0] bWData,
  input  logic        bLock,
  output logic        bGnt,
  output logic        bRValid,
  output logic [31:0] bRData,
  // shared data memory
  output logic        memWriteEnable,
  output logic [2:0]  memFunc3,
  output logic [31:0] memAddr,
  output logic [31:0] memWriteData,
  input  logic [31:0] memReadData
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  typedef enum logic {ARB, LOCK_B} state_t;

  state_t      state, state_next;
  logic [2:0]  wait_cnt;
  logic        a_rv_q, b_rv_q;
  logic [31:0] a_rdata_q, b_rdata_q;

  // Grant selection and lock sequencing; reset blocks every grant.
  always_comb begin
    aGnt       = 1'b0;
    bGnt       = 1'b0;
    state_next = state;
    if (!reset) begin
      case (state)
        ARB: begin
          if (bReq && wait_cnt == LIMIT) bGnt = 1'b1;
          else if (aReq)                 aGnt = 1'b1;
          else if (bReq)                 bGnt = 1'b1;
          if (bGnt && bLock) state_next = LOCK_B;
        end
        LOCK_B: begin
          // The lock always covers exactly one cycle; bLock is ignored here.
          bGnt       = bReq;
          state_next = ARB;
        end
        default: state_next = ARB;
      endcase
    end
  end

  assign aStall = aReq & ~aGnt;

  // Drive the shared memory bus from whichever port holds the grant.
  always_comb begin
    memWriteEnable = 1'b0;
    memFunc3       = 3'd0;
    memAddr        = 32'd0;
    memWriteData   = 32'd0;
    if (aGnt) begin
      memWriteEnable = aWrite;
      memFunc3       = aFunc3;
      memAddr        = aAddr;
      memWriteData   = aWData;
    end else if (bGnt) begin
      memWriteEnable = bWrite;
      memFunc3       = bFunc3;
      memAddr        = bAddr;
      memWriteData   = bWData;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ARB;
    else       state <= state_next;
  end

  // Starvation counter: counts cycles B waits while requesting, saturating.
  always_ff @(posedge clk) begin
    if (reset)                 wait_cnt <= 3'd0;
    else if (bGnt || !bReq)    wait_cnt <= 3'd0;
    else if (wait_cnt != LIMIT) wait_cnt <= wait_cnt + 3'd1;
  end

  // Capture load data at the end of the grant cycle; stores leave data alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rv_q    <= 1'b0;
      b_rv_q    <= 1'b0;
      a_rdata_q <= 32'd0;
      b_rdata_q <= 32'd0;
    end else begin
      a_rv_q <= aGnt & ~aWrite;
      b_rv_q <= bGnt & ~bWrite;
      if (aGnt && !aWrite) a_rdata_q <= memReadData;
      if (bGnt && !bWrite) b_rdata_q <= memReadData;
    end
  end

  // A response already registered when reset rises is still suppressed.
  assign aRValid = a_rv_q & ~reset;
  assign bRValid = b_rv_q & ~reset;
  assign aRData  = a_rdata_q;
  assign bRData  = b_rdata_q;

endmodule
